// File: rtl/rv_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package rv_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_st_t;

  // Requester indices.
  localparam int REQ_CORE = 0;
  localparam int REQ_LDR  = 1;

endpackage

// File: rtl/rv_rr_pick2.sv
// Two-way round-robin picker. On a tie, the requester that did not
// win last time is chosen; a lone requester always wins.
module rv_rr_pick2
  import rv_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       win_o,
  output logic       any_o
);

  // Winner index and request-present flag.
  always_comb begin
    any_o = |req_i;
    if (req_i == 2'b11) win_o = ~last_i;
    else                win_o = req_i[REQ_LDR];
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Two-requester arbiter/sequencer for the single-port unified memory.
// One access at a time: issue in IDLE, optional WAIT for longer
// latencies, then a one-cycle RESP that strobes rvalid to the owner.
module rv_mem_arb
  import rv_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  // WAIT spans MEM_LAT-1 cycles, so the counter starts two below MEM_LAT.
  localparam logic [CNT_W-1:0] CNT_INIT = (MEM_LAT >= 2) ? CNT_W'(MEM_LAT - 2) : '0;

  arb_st_t          state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic win, any, issue;

  rv_rr_pick2 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (win),
    .any_o  (any)
  );

  // A command goes out only from IDLE; reset suppresses it so a command
  // is never presented while the arbiter is being cleared.
  assign issue = (state_q == IDLE) && any && !rst;

  // Next-state logic for FSM, owner/last tracking and latency counter.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          owner_d = win;
          last_d  = win;
          if (MEM_LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; last resets to the loader so the core wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory command and grant, driven only in the issue cycle.
  always_comb begin
    gnt       = 2'b00;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue) begin
      gnt       = win ? 2'b10 : 2'b01;
      mem_en    = 1'b1;
      mem_we    = we[win];
      mem_addr  = win ? addr1  : addr0;
      mem_wdata = win ? wdata1 : wdata0;
    end
  end

  // Completion strobe and read data, only in RESP.
  always_comb begin
    rvalid = 2'b00;
    rdata  = '0;
    if (state_q == RESP) begin
      rvalid = owner_q ? 2'b10 : 2'b01;
      rdata  = mem_rdata;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: four instances with MEM_LAT=1..4, a latency-
// accurate memory per instance, and a scoreboard-based cycle model.
module tb_rv_mem_arb;

  localparam int N = 4;

  typedef struct {
    logic [1:0]  own;
    logic        wr;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_v [N];
  logic [1:0]  we;
  logic [31:0] addr0, addr1, wdata0, wdata1;

  logic [1:0]  gnt_v [N];
  logic [1:0]  rvalid_v [N];
  logic [31:0] rdata_v [N];
  logic        busy_v [N];
  logic        men_v [N];
  logic        mwe_v [N];
  logic [31:0] maddr_v [N];
  logic [31:0] mwd_v [N];
  logic [31:0] mrd_v [N];

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    rv_mem_arb #(.MEM_LAT(k + 1), .AW(32), .DW(32)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req_v[k]),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt       (gnt_v[k]),
      .rvalid    (rvalid_v[k]),
      .rdata     (rdata_v[k]),
      .busy      (busy_v[k]),
      .mem_en    (men_v[k]),
      .mem_we    (mwe_v[k]),
      .mem_addr  (maddr_v[k]),
      .mem_wdata (mwd_v[k]),
      .mem_rdata (mrd_v[k])
    );
  end

  // Unwritten locations read back a per-address pattern; 0x100 on
  // instance 0 holds 0xDEADBEEF.
  function automatic logic [31:0] dflt(input int k, input logic [31:0] a);
    return 32'hDEADBEEF ^ ((a ^ 32'h100) * 32'h9E37) ^ (32'(k) << 24);
  endfunction

  // Memory: read data appears exactly MEM_LAT cycles after the command,
  // garbage at any other time.
  logic [31:0] mem_a [N][64];
  logic        wr_ok [N][64];
  logic [31:0] pipe [N][4];
  logic        pv [N][4];

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      for (int j = 3; j > 0; j--) begin
        pipe[k][j] <= pipe[k][j-1];
        pv[k][j]   <= pv[k][j-1];
      end
      pipe[k][0] <= wr_ok[k][maddr_v[k][7:2]] === 1'b1 ? mem_a[k][maddr_v[k][7:2]]
                                                       : dflt(k, maddr_v[k]);
      pv[k][0]   <= men_v[k] & ~mwe_v[k];
      if (rst) begin
        for (int i = 0; i < 64; i++) wr_ok[k][i] <= 1'b0;
        for (int j = 0; j < 4; j++) pv[k][j] <= 1'b0;
      end else if (men_v[k] && mwe_v[k]) begin
        mem_a[k][maddr_v[k][7:2]] <= mwd_v[k];
        wr_ok[k][maddr_v[k][7:2]] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_rd
    assign mrd_v[k] = (pv[k][k] === 1'b1) ? pipe[k][k] : 32'hBAD0BAD0;
  end

  // Scoreboard / reference model state.
  int          checks = 0;
  int          errors = 0;
  int          rem [N];
  logic        lastm [N];
  int          gcnt [N];
  exp_t        sbq [N][$];
  logic [31:0] mdl [N][64];
  logic        mdl_ok [N][64];
  logic        final_chk = 1'b0;
  logic        final_done = 1'b0;

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[lat%0d]: observed %h expected %h", tag, k + 1, obs, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        chk("rst_gnt",    k, 64'(gnt_v[k]),    64'd0);
        chk("rst_rvalid", k, 64'(rvalid_v[k]), 64'd0);
        chk("rst_busy",   k, 64'(busy_v[k]),   64'd0);
        chk("rst_mem",    k, {31'd0, men_v[k], mwe_v[k], maddr_v[k][30:0]}, 64'd0);
        chk("rst_data",   k, {mwd_v[k], rdata_v[k]}, 64'd0);
        rem[k]   = 0;
        lastm[k] = 1'b1;
        gcnt[k]  = 0;
        sbq[k].delete();
        for (int i = 0; i < 64; i++) mdl_ok[k][i] = 1'b0;
      end else if (rem[k] > 0) begin
        chk("busy_hi",   k, 64'(busy_v[k]), 64'd1);
        chk("busy_gnt",  k, {62'd0, gnt_v[k]}, 64'd0);
        chk("busy_men",  k, {maddr_v[k], 31'd0, men_v[k]}, 64'd0);
        rem[k]--;
        if (rem[k] == 0) begin
          if (sbq[k].size() == 0) begin
            chk("sb_empty", k, 64'd0, 64'd1);
          end else begin
            exp_t e;
            e = sbq[k].pop_front();
            chk("rvalid", k, 64'(rvalid_v[k]), 64'(e.own));
            if (!e.wr) chk("rdata", k, 64'(rdata_v[k]), 64'(e.d));
          end
        end else begin
          chk("rvalid_early", k, 64'(rvalid_v[k]), 64'd0);
        end
      end else begin
        chk("idle_busy",   k, {busy_v[k], rvalid_v[k]}, 64'd0);
        chk("idle_rdata",  k, 64'(rdata_v[k]), 64'd0);
        if (req_v[k] != 2'b00) begin
          logic        w;
          logic [31:0] a, d;
          exp_t        e;
          w = (req_v[k] == 2'b11) ? ~lastm[k] : req_v[k][1];
          a = w ? addr1 : addr0;
          d = w ? wdata1 : wdata0;
          chk("gnt",       k, 64'(gnt_v[k]), w ? 64'd2 : 64'd1);
          chk("mem_en",    k, 64'(men_v[k]), 64'd1);
          chk("mem_we",    k, 64'(mwe_v[k]), 64'(we[w]));
          chk("mem_addr",  k, 64'(maddr_v[k]), 64'(a));
          chk("mem_wdata", k, 64'(mwd_v[k]), 64'(d));
          e.own = w ? 2'b10 : 2'b01;
          e.wr  = we[w];
          e.d   = 32'd0;
          if (we[w]) begin
            mdl[k][a[7:2]]    = d;
            mdl_ok[k][a[7:2]] = 1'b1;
          end else begin
            e.d = mdl_ok[k][a[7:2]] ? mdl[k][a[7:2]] : dflt(k, a);
          end
          sbq[k].push_back(e);
          lastm[k] = w;
          rem[k]   = k + 1;
          gcnt[k]++;
        end else begin
          chk("idle_gnt", k, {gnt_v[k], men_v[k], mwe_v[k]}, 64'd0);
          chk("idle_mem", k, {maddr_v[k], mwd_v[k]}, 64'd0);
        end
      end
    end
    if (final_chk && !final_done) begin
      for (int k = 0; k < N; k++) begin
        chk("sb_drain", k, 64'(sbq[k].size()), 64'd0);
        chk("end_idle", k, 64'(rem[k]), 64'd0);
      end
      final_done = 1'b1;
    end
  end

  // Wait (bounded) for the next grant on instance k, then step past it.
  task automatic wait_gnt(input int k);
    int g0;
    g0 = gcnt[k];
    for (int i = 0; i < 60 && gcnt[k] == g0; i++) @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N; k++) req_v[k] = 2'b00;
    we = 2'b00; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    cycles(2);
    rst = 1'b0;
    cycles(1);

    // T2: single core read, MEM_LAT=1.
    addr0 = 32'h100; req_v[0] = 2'b01;
    wait_gnt(0);
    req_v[0] = 2'b00;
    cycles(3);

    // T3: tie right after reset, alternation over 6 grants.
    do_reset();
    addr0 = 32'h104; addr1 = 32'h200; req_v[0] = 2'b11;
    repeat (6) wait_gnt(0);
    req_v[0] = 2'b00;
    cycles(3);

    // T6: continuous ties on MEM_LAT=2 and 4 (period MEM_LAT+1).
    req_v[1] = 2'b11; addr0 = 32'h10; addr1 = 32'h14;
    repeat (4) wait_gnt(1);
    req_v[1] = 2'b00;
    req_v[3] = 2'b11; addr0 = 32'h20; addr1 = 32'h24;
    repeat (4) wait_gnt(3);
    req_v[3] = 2'b00;
    cycles(6);

    // T4: loader write, MEM_LAT=3, then read it back.
    we = 2'b10; addr1 = 32'h40; wdata1 = 32'h5A5A5A5A; req_v[2] = 2'b10;
    wait_gnt(2);
    req_v[2] = 2'b00; we = 2'b00;
    cycles(4);
    req_v[2] = 2'b10;
    wait_gnt(2);
    req_v[2] = 2'b00;
    cycles(4);

    // T5: core request raised and withdrawn while loader is served.
    addr1 = 32'h44; req_v[2] = 2'b10;
    wait_gnt(2);
    req_v[2] = 2'b01; addr0 = 32'h48;
    cycles(1);
    req_v[2] = 2'b00;
    cycles(6);

    // Mixed traffic on MEM_LAT=2.
    for (int i = 0; i < 10; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      we = 2'($urandom_range(0, 3));
      addr0 = {24'd0, 6'($urandom_range(0, 7)), 2'b00};
      addr1 = {24'd0, 6'($urandom_range(0, 7)), 2'b00};
      wdata0 = $urandom; wdata1 = $urandom;
      req_v[1] = r;
      wait_gnt(1);
    end
    req_v[1] = 2'b00; we = 2'b00;
    cycles(4);

    // T1: reset asserted mid-WAIT on MEM_LAT=3; no rvalid afterwards.
    addr0 = 32'h108; req_v[2] = 2'b01;
    wait_gnt(2);
    req_v[2] = 2'b00;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(6);

    final_chk = 1'b1;
    cycles(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
